// File: rtl/multicycle_control_unit_if.sv
// Purpose: control bundle between the multicycle controller and its datapath.
// Latency: none, plain wires. Backpressure: mem_ready carries the cache handshake back to the controller.
// Ports: master = controller (reads instruction fields/flags, drives enables and selects); slave = datapath.
interface multicycle_control_unit_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       func7;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] res_src;
  logic [1:0] imm_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic       trap;
  logic [1:0] fault_code;

  modport master (
    input  op, funct3, func7, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
    output alu_src_a, alu_src_b, res_src, imm_src, alu_ctrl,
    output state, trap, fault_code
  );

  modport slave (
    output op, funct3, func7, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
    input  alu_src_a, alu_src_b, res_src, imm_src, alu_ctrl,
    input  state, trap, fault_code
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Purpose: Moore control FSM for a multicycle RV32 subset core, with memory-stall watchdog and sticky trap.
// Latency: one state per clock; FETCH/MEMREAD/MEMWRITE hold until mem_ready or the stall limit traps.
// Ports: clk, rst_n (async active-low); bus (master modport) carries instruction fields, flags and all controls.
module multicycle_control_unit #(
  parameter bit          ENABLE_BNE  = 1'b1,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // Last wait cycle index allowed before the access is declared hung.
  localparam logic [7:0] WAIT_MAX = 8'(STALL_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, res_src, imm_src;
  logic [2:0] alu_ctrl, alu_dec;
  logic       wait_en;
  logic       br_take;

  // sub only for R-type (op[5]=1) with bit 30 set; I-type addi never subtracts.
  always_comb begin
    alu_dec = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_dec = (bus.op[5] && bus.func7) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  assign br_take = ((bus.funct3 == 3'b000) && bus.zero) ||
                   (ENABLE_BNE && (bus.funct3 == 3'b001) && !bus.zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    wait_d    = '0;
    wait_en   = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    res_src   = 2'b00;
    imm_src   = 2'b00;
    alu_ctrl  = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        wait_en   = 1'b1;
        // IR capture and PC+4 share the cycle the fetch completes.
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            fault_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        // op[5] separates store (0100011) from load (0000011).
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = bus.op[5] ? 2'b01 : 2'b00;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        wait_en  = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        res_src   = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        wait_en   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_dec;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = br_take;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 2'b11;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Unused codes 12-15 are treated as a corrupted decode.
        state_d = S_TRAP;
        fault_d = FC_ILLEGAL;
      end
    endcase

    // Watchdog: counts only while a memory state waits; any state change clears it.
    if (wait_en && !bus.mem_ready) begin
      if (wait_q >= WAIT_MAX) begin
        state_d = S_TRAP;
        fault_d = FC_TIMEOUT;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.adr_src    = adr_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.res_src    = res_src;
  assign bus.imm_src    = imm_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.state      = state_q;
  assign bus.trap       = (state_q == S_TRAP);
  assign bus.fault_code = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (ENABLE_BNE=1 and 0) share stimulus;
// per-cycle expected outputs are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rgw, mrd, mwr, adr;
    logic [1:0] sa, sb, rs, im;
    logic [2:0] alu;
    logic       trap;
    logic [1:0] fc;
    logic [3:0] b_st;
    logic       b_pcw;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       func7, zero, mem_ready;

  int tests_run = 0;
  int tests_failed = 0;

  obs_t  exp_q[$];
  string nm_q[$];

  multicycle_control_unit_if ifa ();
  multicycle_control_unit_if ifb ();

  assign ifa.op = op;        assign ifb.op = op;
  assign ifa.funct3 = funct3; assign ifb.funct3 = funct3;
  assign ifa.func7 = func7;  assign ifb.func7 = func7;
  assign ifa.zero = zero;    assign ifb.zero = zero;
  assign ifa.mem_ready = mem_ready; assign ifb.mem_ready = mem_ready;

  multicycle_control_unit #(.ENABLE_BNE(1'b1), .STALL_LIMIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  multicycle_control_unit #(.ENABLE_BNE(1'b0), .STALL_LIMIT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output table per state, spec values with conditional fields left 0.
  function automatic obs_t base(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.b_st = st;
    case (st)
      4'd0:  begin e.mrd = 1; e.sb = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; e.im = 2'b10; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.mrd = 1; e.adr = 1; end
      4'd4:  begin e.rgw = 1; e.rs = 2'b01; end
      4'd5:  begin e.mwr = 1; e.adr = 1; end
      4'd6:  begin e.sa = 2'b10; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd8:  begin e.rgw = 1; end
      4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.im = 2'b11;
                   e.pcw = 1; e.rgw = 1; e.b_pcw = 1; end
      4'd11: begin e.trap = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t fetch_rdy();
    obs_t e;
    e = base(4'd0);
    e.irw = 1; e.pcw = 1; e.b_pcw = 1;
    return e;
  endfunction

  function automatic obs_t trap_fc(input logic [1:0] fc);
    obs_t e;
    e = base(4'd11);
    e.fc = fc;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then move to just after the next rising edge.
  task automatic cyc(input string nm, input obs_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] alu);
    obs_t e;
    op = o; funct3 = f3; func7 = f7;
    mem_ready = 1; cyc({nm, "_fetch"}, fetch_rdy());
    cyc({nm, "_decode"}, base(4'd1));              // mem_ready high here is ignored
    e = base(o[5] ? 4'd6 : 4'd7);
    e.alu = alu;
    cyc({nm, "_exec"}, e);
    mem_ready = 0; cyc({nm, "_aluwb"}, base(4'd8));
  endtask

  task automatic run_br(input string nm, input logic [2:0] f3, input logic z,
                        input logic pcw_a, input logic pcw_b);
    obs_t e;
    op = 7'b1100011; funct3 = f3; func7 = 0; zero = z;
    mem_ready = 1; cyc({nm, "_fetch"}, fetch_rdy());
    mem_ready = 0; cyc({nm, "_decode"}, base(4'd1));
    e = base(4'd9);
    e.pcw = pcw_a; e.b_pcw = pcw_b;
    cyc({nm, "_branch"}, e);
  endtask

  task automatic store_prefix(input string nm);
    obs_t e;
    op = 7'b0100011; funct3 = 3'b010; func7 = 0;
    mem_ready = 1; cyc({nm, "_fetch"}, fetch_rdy());
    mem_ready = 0; cyc({nm, "_decode"}, base(4'd1));
    e = base(4'd2); e.im = 2'b01;
    cyc({nm, "_memadr"}, e);
  endtask

  // Monitor: compares both instances against the queued expectation at every negedge.
  initial begin
    obs_t act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        act.st = ifa.state;     act.pcw = ifa.pc_write;  act.irw = ifa.ir_write;
        act.rgw = ifa.reg_write; act.mrd = ifa.mem_read; act.mwr = ifa.mem_write;
        act.adr = ifa.adr_src;  act.sa = ifa.alu_src_a;  act.sb = ifa.alu_src_b;
        act.rs = ifa.res_src;   act.im = ifa.imm_src;    act.alu = ifa.alu_ctrl;
        act.trap = ifa.trap;    act.fc = ifa.fault_code;
        act.b_st = ifb.state;   act.b_pcw = ifb.pc_write;
        tests_run++;
        if (act !== e) begin
          tests_failed++;
          $display("FAIL %s: got %h expected %h (state %0d vs %0d)", nm, act, e, act.st, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    rst_n = 0; op = 7'b0110011; funct3 = 0; func7 = 0; zero = 0; mem_ready = 0;
    @(posedge clk); #1;

    // Reset state and release.
    cyc("rst_hold0", base(4'd0));
    cyc("rst_hold1", base(4'd0));
    rst_n = 1;
    cyc("rel_fetch", base(4'd0));
    cyc("fetch_wait", base(4'd0));

    // ALU decode across patterns.
    run_alu("add",   7'b0110011, 3'b000, 1'b0, 3'b000);
    run_alu("sub",   7'b0110011, 3'b000, 1'b1, 3'b001);
    run_alu("addi7", 7'b0010011, 3'b000, 1'b1, 3'b000);
    run_alu("slti",  7'b0010011, 3'b010, 1'b0, 3'b101);
    run_alu("or",    7'b0110011, 3'b110, 1'b0, 3'b011);
    run_alu("andi",  7'b0010011, 3'b111, 1'b1, 3'b010);
    run_alu("xor",   7'b0110011, 3'b100, 1'b0, 3'b000);

    // lw with three stalled MEMREAD cycles.
    op = 7'b0000011; funct3 = 3'b010; func7 = 0;
    mem_ready = 1; cyc("lw_fetch", fetch_rdy());
    mem_ready = 0; cyc("lw_decode", base(4'd1));
    cyc("lw_memadr", base(4'd2));
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", base(4'd3));
    mem_ready = 1; cyc("lw_memread_done", base(4'd3));
    mem_ready = 0; cyc("lw_memwb", base(4'd4));

    // sw with one wait; mem_write drops the cycle after mem_ready.
    store_prefix("sw");
    cyc("sw_memwrite_wait", base(4'd5));
    mem_ready = 1; cyc("sw_memwrite_done", base(4'd5));
    mem_ready = 0; cyc("sw_after", base(4'd0));

    // Branches on both parameterisations.
    run_br("beq_z1", 3'b000, 1'b1, 1'b1, 1'b1);
    run_br("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
    run_br("bne_z0", 3'b001, 1'b0, 1'b1, 1'b0);
    run_br("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
    run_br("blt_z0", 3'b100, 1'b0, 1'b0, 1'b0);

    // jal
    op = 7'b1101111; zero = 0;
    mem_ready = 1; cyc("jal_fetch", fetch_rdy());
    mem_ready = 0; cyc("jal_decode", base(4'd1));
    cyc("jal_exec", base(4'd10));

    // Store that never completes: 16 MEMWRITE cycles then TRAP with timeout code.
    store_prefix("swto");
    for (int i = 0; i < 16; i++) cyc("swto_memwrite", base(4'd5));
    mem_ready = 1;
    for (int i = 0; i < 3; i++) cyc("swto_trap", trap_fc(2'b10));

    // Asynchronous reset out of TRAP, checked before any rising edge.
    mem_ready = 0; rst_n = 0;
    cyc("rst_async_trap", base(4'd0));
    rst_n = 1;
    cyc("rel_after_trap", base(4'd0));

    // Illegal opcode.
    op = 7'b1111111;
    mem_ready = 1; cyc("ill_fetch", fetch_rdy());
    mem_ready = 0; cyc("ill_decode", base(4'd1));
    cyc("ill_trap0", trap_fc(2'b01));
    cyc("ill_trap1", trap_fc(2'b01));
    rst_n = 0;
    cyc("rst_async_ill", base(4'd0));
    rst_n = 1;
    cyc("rel_after_ill", base(4'd0));

    // Reset in the middle of a store drops mem_write without a clock edge.
    store_prefix("swrst");
    cyc("swrst_memwrite", base(4'd5));
    rst_n = 0;
    cyc("rst_async_memwrite", base(4'd0));
    rst_n = 1;
    cyc("swrst_release", base(4'd0));
    mem_ready = 1; cyc("swrst_fetch", fetch_rdy());
    mem_ready = 0; cyc("swrst_decode", base(4'd1));

    @(negedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL take parameter ENABLE_BNE, default 1; 1 decodes beq (funct3=000) and bne (funct3=001), 0 decodes beq only.
REQ-002 SHALL take parameter STALL_LIMIT, default 16, range 2..255; maximum cycles one memory access may wait for mem_ready.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  7  opcode of the instruction register.
REQ-006 funct3  in  3  instruction bits 14:12.
REQ-007 func7  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU result-is-zero flag.
REQ-009 mem_ready  in  1  cache handshake: current access completes this cycle.
REQ-010 pc_write, ir_write, reg_write, mem_read, mem_write, adr_src  out  1 each  PC/IR/regfile enables, memory strobes, address select (0=PC, 1=ALU result register).
REQ-011 alu_src_a, alu_src_b, res_src, imm_src  out  2 each  datapath mux selects.
REQ-012 alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 state  out  4  current FSM state code; trap  out  1  sticky fault flag; fault_code  out  2  01 illegal opcode, 10 memory timeout.

Function
REQ-014 SHALL implement a Moore FSM with encoded states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11; codes 12-15 go to TRAP with fault_code=01.
REQ-015 FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add; holds until mem_ready=1, then ir_write=1 and pc_write=1 in that same cycle, next DECODE.
REQ-016 DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, else TRAP with fault_code=01.
REQ-017 MEMADR: alu_src_a=10, alu_src_b=01, add; imm_src=00 for load, 01 for store; next MEMREAD for load, MEMWRITE for store.
REQ-018 MEMREAD: mem_read=1, adr_src=1; on mem_ready next MEMWB; MEMWB: reg_write=1, res_src=01, next FETCH.
REQ-019 MEMWRITE: mem_write=1, adr_src=1; on mem_ready next FETCH; mem_write SHALL deassert the cycle after mem_ready.
REQ-020 EXECR: alu_src_a=10, alu_src_b=00; EXECI: alu_src_a=10, alu_src_b=01, imm_src=00; both next ALUWB; ALUWB: reg_write=1, res_src=00, next FETCH.
REQ-021 ALU decode in EXECR/EXECI on {funct3, op[5], func7}: funct3=000 -> sub only when op[5]=1 and func7=1, else add; 010->slt; 110->or; 111->and; any other -> add.
REQ-022 BRANCH: alu_src_a=10, alu_src_b=00, sub, res_src=00; pc_write = zero for funct3=000; = ~zero for funct3=001 when ENABLE_BNE=1; otherwise 0; next FETCH.
REQ-023 JAL: alu_src_a=01, alu_src_b=10, imm_src=11, add, res_src=00, pc_write=1, reg_write=1; next FETCH.
REQ-024 SHALL count wait cycles in FETCH, MEMREAD, MEMWRITE; counter clears on state entry and on mem_ready; reaching STALL_LIMIT without mem_ready -> TRAP with fault_code=10, no strobes in TRAP.
REQ-025 TRAP: all enables/strobes 0, trap=1, fault_code held; state stays TRAP until reset.
REQ-026 mem_ready outside FETCH/MEMREAD/MEMWRITE SHALL be ignored.
REQ-027 All unlisted outputs in any state SHALL be 0.

Reset
REQ-028 rst_n=0 SHALL immediately force state=FETCH, wait counter=0, trap=0, fault_code=00, regardless of clk.
REQ-029 Reset mid-access (e.g. MEMWRITE) SHALL drop mem_write asynchronously; after release FETCH begins on the next rising edge.

Verification
REQ-030 add x3,x1,x2 (op=0110011,f3=000,f7=0), mem_ready=1 in FETCH -> states 0,1,6,8,0; reg_write=1 only in ALUWB; alu_ctrl=000 in EXECR.
REQ-031 lw, mem_ready delayed 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MEMWB reg_write=1 res_src=01; total 8 cycles.
REQ-032 bne with zero=0, ENABLE_BNE=1 -> pc_write=1 in BRANCH; same with ENABLE_BNE=0 -> pc_write=0.
REQ-033 sw with mem_ready never asserted, STALL_LIMIT=16 -> TRAP after 16 MEMWRITE cycles, fault_code=10, mem_write=0 thereafter.
REQ-034 op=1111111 in DECODE -> TRAP, fault_code=01; rst_n pulse low -> state=0, trap=0 without clock edge.
